serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 23 ++
 rtl/serial_adder.sv | 101 ++++++++++
 tb/tb_serial_adder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, one bit per clock,
// LSB first. Result and carry-out are held until the next operation completes.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             c_q,      c_d;
    logic             cout_q,   cout_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             fa_s;
    logic             fa_c;

    // Full-adder cell on the current LSBs and the stored carry.
    always_comb begin
        fa_s = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
        fa_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
    end

    // Next-state and datapath update; DONE accepts a new start like IDLE.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        c_d      = c_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    c_d     = bus.cin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                c_d      = fa_c;
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Final bit: publish the completed word straight into the
                    // held result so partial sums are never visible.
                    sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            c_q      <= c_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy = (state_q == ST_SHIFT);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: behavioural model plus directed literal checks.
module tb_serial_adder;
    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: an accepted start yields a+b+cin after W busy cycles.
    int           m_left;
    logic         m_done;
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic [W:0]   m_pend;
    logic         check_en;

    initial begin
        m_left   = 0;
        m_done   = 1'b0;
        m_sum    = '0;
        m_cout   = 1'b0;
        m_pend   = '0;
        check_en = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_sum    <= '0;
            m_cout   <= 1'b0;
            check_en <= 1'b1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) {m_cout, m_sum} <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_pend <= {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
                m_left <= W;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", {31'd0, bus.busy}, {31'd0, (m_left > 0)});
            chk("done", {31'd0, bus.done}, {31'd0, m_done});
            chk("sum",  {24'd0, bus.sum},  {24'd0, m_sum});
            chk("cout", {31'd0, bus.cout}, {31'd0, m_cout});
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Launch one operation, scramble operands afterwards, wait for done.
    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                      input logic [W-1:0] es, input logic ec, input bit poke);
        int lat;
        lat = 0;
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        bus.cin   = ic;
        tick();
        bus.start = 1'b0;
        bus.a     = '1;
        bus.b     = '1;
        bus.cin   = 1'b1;
        for (int i = 1; i <= 3 * W; i++) begin
            @(negedge clk);
            if (poke && i == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'h33;
                bus.b     = 8'h44;
            end
            if (poke && i == 4) bus.start = 1'b0;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk("latency",   lat,                W + 1);
        chk("lit_sum",   {24'd0, bus.sum},   {24'd0, es});
        chk("lit_cout",  {31'd0, bus.cout},  {31'd0, ec});
        chk("model_sum", {23'd0, m_cout, m_sum}, {23'd0, ec, es});
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_sum",  {24'd0, bus.sum},  32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        rst = 1'b0;
        tick();

        op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        op(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b0);
        tick();
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        tick();
        // Ignored start mid-operation, then back-to-back from the DONE cycle.
        op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);
        op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        tick();

        // Reset during the 4th SHIFT cycle aborts the operation.
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.cin   = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_sum",  {24'd0, bus.sum},  32'd0);
        chk("abort_cout", {31'd0, bus.cout}, 32'd0);
        rst = 1'b0;
        tick();
        op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        tick();

        // Randomized traffic, including occasional resets and stray starts.
        repeat (500) begin
            rst       = ($urandom_range(0, 79) == 0);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.cin   = 1'($urandom);
            tick();
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (3 * W) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
